// File: rtl/calc_op_sequencer.sv
// Control sequencer for one calculator operation: operand capture, validation,
// unit launch, completion/error reporting, with a watchdog on the running unit.
module calc_op_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int OP_W        = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load,
  input  logic [OP_W-1:0] op,
  input  logic            val_error,
  input  logic [2:0]      unit_ready,
  output logic            load_x,
  output logic            load_y,
  output logic            val_en,
  output logic [2:0]      unit_start,
  output logic [OP_W-1:0] alu_sel,
  output logic            result_load,
  output logic            ready,
  output logic            error,
  output logic            timeout,
  output logic            busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [OP_W-1:0]  OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0]  OP_DIV   = OP_W'(1);
  localparam logic [OP_W-1:0]  OP_SQRT  = OP_W'(2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_Y,
    S_ARMED,
    S_VALIDATE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_d;
  logic [OP_W-1:0]   op_q, op_q_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              vld_second, vld_second_d;
  logic              unit_hit;
  logic              op_reserved;

  logic              load_x_d, load_y_d, val_en_d, result_load_d;
  logic              ready_d, error_d, timeout_d, busy_d;
  logic [2:0]        unit_start_d;
  logic [OP_W-1:0]   alu_sel_d;

  // Only the ready line of the locked unit matters; the others are ignored.
  always_comb begin
    unit_hit = 1'b0;
    case (op_q)
      OP_MULT: unit_hit = unit_ready[0];
      OP_DIV:  unit_hit = unit_ready[1];
      OP_SQRT: unit_hit = unit_ready[2];
      default: unit_hit = 1'b0;
    endcase
  end

  assign op_reserved = (op_q > OP_SQRT);

  // State register; outputs are registered alongside so every port is glitch-free.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      cnt         <= '0;
      vld_second  <= 1'b0;
      load_x      <= 1'b0;
      load_y      <= 1'b0;
      val_en      <= 1'b0;
      unit_start  <= 3'b000;
      alu_sel     <= '0;
      result_load <= 1'b0;
      ready       <= 1'b0;
      error       <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_q_d;
      cnt         <= cnt_d;
      vld_second  <= vld_second_d;
      load_x      <= load_x_d;
      load_y      <= load_y_d;
      val_en      <= val_en_d;
      unit_start  <= unit_start_d;
      alu_sel     <= alu_sel_d;
      result_load <= result_load_d;
      ready       <= ready_d;
      error       <= error_d;
      timeout     <= timeout_d;
      busy        <= busy_d;
    end
  end

  // Next-state logic. Load always wins over a simultaneous start.
  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state;
    op_q_d       = op_q;
    cnt_d        = cnt;
    vld_second_d = vld_second;
    case (state)
      S_IDLE:   if (load) state_d = S_WAIT_Y;
      S_WAIT_Y: if (load) state_d = S_ARMED;
      S_ARMED, S_DONE: begin
        if (load) begin
          state_d = (state == S_DONE) ? S_WAIT_Y : S_ARMED;
        end else if (start) begin
          op_q_d       = op;
          vld_second_d = 1'b0;
          state_d      = S_VALIDATE;
        end
      end
      S_VALIDATE: begin
        if (!vld_second) begin
          vld_second_d = 1'b1;
        end else if (op_reserved || val_error) begin
          state_d = S_ERR;
        end else begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (unit_hit) begin
          state_d = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
      end
      S_ERR:    if (load) state_d = S_WAIT_Y;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: values the output flops take at the coming edge, derived from the transition.
  always_comb begin
    load_x_d      = (state_d == S_WAIT_Y) && (state != S_WAIT_Y);
    load_y_d      = ((state == S_WAIT_Y) && (state_d == S_ARMED)) ||
                    ((state == S_ARMED) && load);
    val_en_d      = (state_d == S_VALIDATE) && (state != S_VALIDATE);
    unit_start_d  = 3'b000;
    if ((state_d == S_RUN) && (state != S_RUN)) begin
      case (op_q)
        OP_MULT: unit_start_d = 3'b001;
        OP_DIV:  unit_start_d = 3'b010;
        OP_SQRT: unit_start_d = 3'b100;
        default: unit_start_d = 3'b000;
      endcase
    end
    alu_sel_d     = (state_d == S_RUN) ? op_q : alu_sel;
    result_load_d = (state == S_RUN) && (state_d == S_DONE);
    ready_d       = (state_d == S_DONE);
    error_d       = (state_d == S_ERR);
    // RUN only exits to ERR through the watchdog; the flag then holds until ERR is left.
    timeout_d     = (state_d == S_ERR) &&
                    ((state == S_RUN) || ((state == S_ERR) && timeout));
    busy_d        = (state_d == S_VALIDATE) || (state_d == S_RUN);
  end

endmodule
